// File: rtl/analog_scan_if.sv
// Sample/result bus between the ADC front end and the channel scanner.
// The slave side is the scanner; the master side is the ADC plus result consumers.
interface analog_scan_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 10
);
  logic                         enable;
  logic [3:0]                   channel;
  logic                         new_sample;
  logic [SAMPLE_W-1:0]          sample;
  logic [3:0]                   sample_channel;
  logic [NUM_CH*SAMPLE_W-1:0]   out;
  logic                         out_valid;
  logic [3:0]                   out_channel;
  logic                         scan_done;

  modport master (
    output enable, new_sample, sample, sample_channel,
    input  channel, out, out_valid, out_channel, scan_done
  );

  modport slave (
    input  enable, new_sample, sample, sample_channel,
    output channel, out, out_valid, out_channel, scan_done
  );
endinterface

// File: rtl/analog_scan.sv
// Round-robin ADC channel scanner: discards settling samples after each mux switch,
// averages 2**AVG_LOG2 tagged samples per channel and holds one result per channel.
module analog_scan #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 10,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 1
) (
  input  logic          clk,
  input  logic          rst,
  analog_scan_if.slave  bus
);
  localparam int ACC_W  = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int DISC_W = $clog2(SETTLE + 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [3:0]        CH_LAST   = 4'(NUM_CH - 1);

  typedef enum logic {
    S_DISCARD,
    S_ACCUM
  } state_t;

  localparam state_t S_START = (SETTLE > 0) ? S_DISCARD : S_ACCUM;

  state_t                       r_state;
  logic [3:0]                   r_ch;
  logic [ACC_W-1:0]             r_acc;
  logic [CNT_W-1:0]             r_cnt;
  logic [DISC_W-1:0]            r_disc;
  logic [NUM_CH*SAMPLE_W-1:0]   r_out;
  logic                         r_out_valid;
  logic [3:0]                   r_out_ch;
  logic                         r_scan_done;

  logic                         w_accept;
  logic [ACC_W-1:0]             w_sum;
  logic [SAMPLE_W-1:0]          w_avg;
  logic [3:0]                   w_ch_next;

  // Strobes tagged with a channel other than the pointer come from a stale mux setting.
  assign w_accept  = bus.new_sample & bus.enable & (bus.sample_channel == r_ch);
  assign w_sum     = r_acc + ACC_W'(bus.sample);
  assign w_avg     = SAMPLE_W'(w_sum >> AVG_LOG2);
  assign w_ch_next = (r_ch == CH_LAST) ? '0 : r_ch + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_START;
      r_ch        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_disc      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_scan_done <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_DISCARD: begin
            if (r_disc == DISC_LAST) begin
              r_disc  <= '0;
              r_state <= S_ACCUM;
            end else begin
              r_disc <= r_disc + DISC_W'(1);
            end
          end
          S_ACCUM: begin
            if (r_cnt == CNT_LAST) begin
              r_out[r_ch*SAMPLE_W +: SAMPLE_W] <= w_avg;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_out_valid <= 1'b1;
              r_out_ch    <= r_ch;
              r_scan_done <= (r_ch == CH_LAST);
              r_ch        <= w_ch_next;
              r_state     <= S_START;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= S_START;
        endcase
      end
    end
  end

  assign bus.channel     = r_ch;
  assign bus.out         = r_out;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_channel = r_out_ch;
  assign bus.scan_done   = r_scan_done;
endmodule
